// File: rtl/pipe_reg_hs.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapsing,
// synchronous flush and an occupancy count.
module pipe_reg_hs #(
  parameter int unsigned n          = 32,
  parameter int          DEPTH      = 2,
  parameter logic [n-1:0] RESET_DATA = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [n-1:0]                 in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [n-1:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  if (DEPTH < 1) begin : g_depth_chk
    $error("pipe_reg_hs: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] v_q, v_d;
  logic [n-1:0]     d_q [DEPTH];
  logic [n-1:0]     d_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DEPTH:0]   rdy_c;

  // Ready ripples back from the output; an empty stage always accepts.
  always_comb begin
    rdy_c        = '0;
    rdy_c[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_c[i] = !v_q[i] | rdy_c[i+1];
    end
  end

  // Stage advance; data only loads on a valid word so bubbles leave it quiet.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy_c[0]) begin
        v_d[0] = in_valid;
        if (in_valid) d_d[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy_c[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) d_d[i] = d_q[i-1];
        end
      end
    end
  end

  // Occupancy is tracked as a register so it has no path from the inputs.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RESET_DATA;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      d_q   <= d_d;
    end
  end

  assign in_ready  = rdy_c[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: directed vector table on DEPTH=3, reset sequence,
// and random valid/ready/flush stress on DEPTH=1,3,4 against a queue model.
module tb_pipe_reg_hs;

  localparam int unsigned W       = 8;
  localparam logic [7:0]  RST_VAL = 8'hC3;
  localparam int          NI      = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv  [NI];
  logic       orr [NI];
  logic       fl  [NI];
  logic       ir  [NI];
  logic       ov  [NI];
  logic [7:0] id  [NI];
  logic [7:0] od  [NI];
  logic [2:0] occ [NI];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int dep(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    localparam int OW = $clog2(D + 1);
    logic [OW-1:0] occ_w;
    pipe_reg_hs #(.n(W), .DEPTH(D), .RESET_DATA(RST_VAL)) u_dut (
      .clk(clk), .rst(rst), .flush(fl[g]),
      .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
      .out_valid(ov[g]), .out_ready(orr[g]), .out_data(od[g]),
      .occupancy(occ_w)
    );
    assign occ[g] = 3'(occ_w);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       orr;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    int         e_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                              input logic f, input logic eir, input logic eov,
                              input logic [7:0] eod, input int eocc);
    vec_t t;
    t.iv = v; t.id = d; t.orr = r; t.fl = f;
    t.e_ir = eir; t.e_ov = eov; t.e_od = eod; t.e_occ = eocc;
    return t;
  endfunction

  logic [7:0] mq [NI][$];
  bit         pend   [NI];
  bit         hold   [NI];
  logic [7:0] hold_d [NI];
  int         starve [NI];

  initial begin
    for (int g = 0; g < NI; g++) begin
      iv[g] = 0; orr[g] = 0; fl[g] = 0; id[g] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst%0d out_valid", g), ov[g], 0);
      chk($sformatf("rst%0d occupancy", g), occ[g], 0);
      chk($sformatf("rst%0d out_data", g), od[g], RST_VAL);
      chk($sformatf("rst%0d in_ready", g), ir[g], 1);
    end
    @(negedge clk);
    rst = 0;

    // Rows: inputs for one cycle, in_ready before the edge, outputs after it.
    tbl.push_back(mk(1, 8'h11, 1, 0, 1, 0, RST_VAL, 1));
    tbl.push_back(mk(1, 8'h22, 1, 0, 1, 0, RST_VAL, 2));
    tbl.push_back(mk(1, 8'h33, 1, 0, 1, 1, 8'h11, 3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h22, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h33, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h33, 0));
    tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 8'h33, 1));
    tbl.push_back(mk(1, 8'hA2, 0, 0, 1, 0, 8'h33, 2));
    tbl.push_back(mk(1, 8'hA3, 0, 0, 1, 1, 8'hA1, 3));
    tbl.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 8'hA1, 3));
    tbl.push_back(mk(1, 8'hA4, 1, 0, 1, 1, 8'hA2, 3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA3, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA4, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hA4, 0));
    tbl.push_back(mk(1, 8'h01, 0, 0, 1, 0, 8'hA4, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'hA4, 1));
    tbl.push_back(mk(1, 8'h02, 0, 0, 1, 1, 8'h01, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h01, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h01, 2));
    tbl.push_back(mk(1, 8'h03, 0, 0, 1, 1, 8'h01, 3));
    tbl.push_back(mk(1, 8'h55, 1, 1, 1, 0, 8'h01, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h01, 0));

    foreach (tbl[k]) begin
      @(negedge clk);
      iv[1] = tbl[k].iv; id[1] = tbl[k].id; orr[1] = tbl[k].orr; fl[1] = tbl[k].fl;
      #1;
      chk($sformatf("vec%0d in_ready", k), ir[1], tbl[k].e_ir);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", k), ov[1], tbl[k].e_ov);
      chk($sformatf("vec%0d out_data", k), od[1], tbl[k].e_od);
      chk($sformatf("vec%0d occupancy", k), occ[1], tbl[k].e_occ);
    end

    // Asynchronous reset between edges with words in flight.
    @(negedge clk);
    iv[1] = 1; id[1] = 8'h88; orr[1] = 0; fl[1] = 0;
    @(negedge clk);
    id[1] = 8'h99;
    @(posedge clk);
    #1;
    chk("pre-reset occupancy", occ[1], 2);
    #2;
    rst = 1;
    #1;
    chk("async rst out_valid", ov[1], 0);
    chk("async rst occupancy", occ[1], 0);
    chk("async rst out_data", od[1], RST_VAL);
    chk("async rst in_ready", ir[1], 1);
    @(posedge clk);
    #1;
    chk("rst held occupancy", occ[1], 0);
    @(negedge clk);
    rst = 0; iv[1] = 1; id[1] = 8'h77; orr[1] = 1;
    @(posedge clk);
    #1;
    chk("0x77 edge0 out_valid", ov[1], 0);
    chk("0x77 edge0 occupancy", occ[1], 1);
    @(negedge clk);
    iv[1] = 0;
    @(posedge clk);
    #1;
    chk("0x77 edge1 out_valid", ov[1], 0);
    @(posedge clk);
    #1;
    chk("0x77 edge2 out_valid", ov[1], 1);
    chk("0x77 edge2 out_data", od[1], 8'h77);

    // Random stress on all instances against an in-order queue model.
    @(negedge clk);
    rst = 1;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 0; orr[g] = 0; fl[g] = 0;
      pend[g] = 0; hold[g] = 0; starve[g] = 0; hold_d[g] = '0;
      mq[g].delete();
    end
    @(negedge clk);
    rst = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("rnd%0d occupancy", g), occ[g], mq[g].size());
        if (mq[g].size() == 0) chk($sformatf("rnd%0d out_valid empty", g), ov[g], 0);
        if (ov[g] && mq[g].size() > 0) chk($sformatf("rnd%0d out_data order", g), od[g], mq[g][0]);
        if (hold[g]) begin
          chk($sformatf("rnd%0d stall valid", g), ov[g], 1);
          chk($sformatf("rnd%0d stall data", g), od[g], hold_d[g]);
        end
        if (mq[g].size() > 0 && !ov[g]) starve[g]++;
        else starve[g] = 0;
        chk($sformatf("rnd%0d drain bound", g), int'(starve[g] < dep(g)), 1);
      end
      for (int g = 0; g < NI; g++) begin
        fl[g]  = ($urandom_range(31) == 0);
        orr[g] = ($urandom_range(9) < 6);
        if (!pend[g]) begin
          iv[g] = ($urandom_range(9) < 6);
          id[g] = 8'($urandom);
        end
      end
      #1;
      for (int g = 0; g < NI; g++) begin
        bit exp_r, in_x, out_x;
        exp_r = (mq[g].size() < dep(g)) || orr[g];
        chk($sformatf("rnd%0d in_ready", g), ir[g], exp_r);
        in_x  = iv[g] && exp_r;
        out_x = ov[g] && orr[g];
        if (fl[g]) begin
          mq[g].delete();
          pend[g] = 0;
          hold[g] = 0;
        end else begin
          if (out_x && mq[g].size() > 0) void'(mq[g].pop_front());
          if (in_x) mq[g].push_back(id[g]);
          pend[g] = iv[g] && !in_x;
          hold[g] = ov[g] && !orr[g];
        end
        hold_d[g] = od[g];
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
